// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers of the RV32IM core:
// control-vector defaults, control field offsets and counter helpers.
package pipe_pkg;

   localparam int CTRL_W_DEF = 16;
   localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE_DEF = '0;

   // Widest event counter the helper below can reason about.
   localparam int CNT_MAX_W = 32;

   // Bit offsets of the fields packed into the control vector.
   localparam int REG_WR_BIT   = 0;   // [0]     register-file write enable
   localparam int WB_SEL_LSB   = 1;   // [2:1]   write-back source select
   localparam int FUNCT3_LSB   = 3;   // [5:3]   funct3
   localparam int OPCODE_LSB   = 6;   // [12:6]  opcode
   localparam int BR_TAKEN_BIT = 13;  // [13]    branch taken
   localparam int LWSTALL_BIT  = 14;  // [14]    load-use stall marker

   // Saturating-increment helper: true while a counter of width w holding
   // value v can still be incremented without passing 2^w-1.
   function automatic logic sat_inc_ok(input logic [CNT_MAX_W-1:0] v,
                                       input int unsigned          w);
      logic [CNT_MAX_W-1:0] max_v;
      max_v = (w >= CNT_MAX_W) ? '1
                               : ((CNT_MAX_W'(1) << w) - CNT_MAX_W'(1));
      return (v < max_v);
   endfunction

endpackage

// File: rtl/pipe_stage_reg_stage.sv
// One pipeline slot (valid, control, data) with rst > flush > stall > load priority.
module pipe_stage
   import pipe_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                NUM_CH      = 4,
   parameter int                CTRL_W      = CTRL_W_DEF,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEF)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     valid_d,
   input  logic [CTRL_W-1:0]        ctrl_d,
   input  logic [NUM_CH*DATA_W-1:0] data_d,
   output logic                     valid_q,
   output logic [CTRL_W-1:0]        ctrl_q,
   output logic [NUM_CH*DATA_W-1:0] data_q
);

   // Slot register: reset/flush insert a clean bubble, stall holds, otherwise load.
   // NOTE: non-blocking (<=) keeps every stage sampling its neighbour's old value,
   // so the chain shifts by exactly one slot per edge.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_BUBBLE;
         data_q  <= '0;
      end else if (!stall) begin
         valid_q <= valid_d;
         // An invalid slot must never carry live write enables downstream.
         ctrl_q  <= valid_d ? ctrl_d : CTRL_BUBBLE;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH chained slots plus
// saturating stall/flush event counters.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                NUM_CH      = 4,
   parameter int                CTRL_W      = CTRL_W_DEF,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEF),
   parameter int                DEPTH       = 1,
   parameter int                CNT_W       = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall_i,
   input  logic                     flush_i,
   input  logic                     valid_i,
   input  logic [CTRL_W-1:0]        ctrl_i,
   input  logic [NUM_CH*DATA_W-1:0] data_i,
   output logic                     valid_o,
   output logic [CTRL_W-1:0]        ctrl_o,
   output logic [NUM_CH*DATA_W-1:0] data_o,
   output logic [CNT_W-1:0]         stall_cnt_o,
   output logic [CNT_W-1:0]         flush_cnt_o
);

   // Index 0 is the input slot; index k is the output of stage k-1.
   logic                     valid_s [DEPTH+1];
   logic [CTRL_W-1:0]        ctrl_s  [DEPTH+1];
   logic [NUM_CH*DATA_W-1:0] data_s  [DEPTH+1];

   assign valid_s[0] = valid_i;
   assign ctrl_s[0]  = ctrl_i;
   assign data_s[0]  = data_i;

   genvar g;
   for (g = 0; g < DEPTH; g++) begin : g_stage
      pipe_stage #(
         .DATA_W      (DATA_W),
         .NUM_CH      (NUM_CH),
         .CTRL_W      (CTRL_W),
         .CTRL_BUBBLE (CTRL_BUBBLE)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .stall   (stall_i),
         .flush   (flush_i),
         .valid_d (valid_s[g]),
         .ctrl_d  (ctrl_s[g]),
         .data_d  (data_s[g]),
         .valid_q (valid_s[g+1]),
         .ctrl_q  (ctrl_s[g+1]),
         .data_q  (data_s[g+1])
      );
   end

   assign valid_o = valid_s[DEPTH];
   assign ctrl_o  = ctrl_s[DEPTH];
   assign data_o  = data_s[DEPTH];

   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // Event counters: flush wins over stall, both saturate and clear only on rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else if (flush_i) begin
         if (sat_inc_ok(CNT_MAX_W'(flush_cnt_q), CNT_W))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end else if (stall_i) begin
         if (sat_inc_ok(CNT_MAX_W'(stall_cnt_q), CNT_W))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule
